// File: rtl/muldiv_e.sv
// muldiv_e: iterative MIPS mult/multu/div/divu execute-stage unit writing HI/LO.
// Divider datapath present only when MULDIV_DIV_EN is defined; default build is multiply-only.
module muldiv_e #(
   parameter int unsigned N = 32
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         startE,
   input  logic [1:0]   opE,
   input  logic [N-1:0] srcAE,
   input  logic [N-1:0] srcBE,
   output logic         busyE,
   output logic         doneE,
   output logic [N-1:0] hiE,
   output logic [N-1:0] loE
);
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

   stateT          state;
   logic [CW-1:0]  count;
   logic [N-1:0]   aReg;
   logic [N-1:0]   bReg;
   logic [2*N-1:0] acc;
   logic           negRes;

   logic           accept;
   logic           signA;
   logic           signB;
   logic [N-1:0]   aMag;
   logic [N-1:0]   bMag;
   logic [N-1:0]   addend;
   logic [N:0]     mulSum;
   logic [2*N-1:0] prod;

   assign busyE = (state != IDLE);

`ifdef MULDIV_DIV_EN
   assign accept = startE && (state == IDLE);
`else
   // Divide requests are dropped entirely when the divider is not built.
   assign accept = startE && (state == IDLE) && !opE[1];
`endif

   assign signA = opE[0] & srcAE[N-1];
   assign signB = opE[0] & srcBE[N-1];
   assign aMag  = signA ? ({N{1'b0}} - srcAE) : srcAE;
   assign bMag  = signB ? ({N{1'b0}} - srcBE) : srcBE;

   // Shift-add step: add multiplicand into the upper half, then shift right.
   assign addend = bReg[0] ? aReg : {N{1'b0}};
   assign mulSum = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
   assign prod   = negRes ? ({2*N{1'b0}} - acc) : acc;

`ifdef MULDIV_DIV_EN
   logic         isDiv;
   logic         negRem;
   logic         divZero;
   logic [N-1:0] remReg;
   logic [N:0]   shifted;
   logic         ge;
   logic [N-1:0] diff;
   logic [N-1:0] qOut;
   logic [N-1:0] rOut;

   // Restoring step: quotient bits enter aReg from the right as dividend bits leave the top.
   assign shifted = {remReg, aReg[N-1]};
   assign ge      = shifted >= {1'b0, bReg};
   assign diff    = shifted[N-1:0] - bReg;
   // Divide by zero keeps the all-ones quotient regardless of operand signs.
   assign qOut    = (negRes && !divZero) ? ({N{1'b0}} - aReg) : aReg;
   assign rOut    = negRem ? ({N{1'b0}} - remReg) : remReg;
`endif

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= IDLE;
         count   <= '0;
         doneE   <= 1'b0;
         hiE     <= '0;
         loE     <= '0;
         aReg    <= '0;
         bReg    <= '0;
         acc     <= '0;
         negRes  <= 1'b0;
`ifdef MULDIV_DIV_EN
         isDiv   <= 1'b0;
         negRem  <= 1'b0;
         divZero <= 1'b0;
         remReg  <= '0;
`endif
      end else begin
         doneE <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  aReg   <= aMag;
                  bReg   <= bMag;
                  acc    <= '0;
                  negRes <= signA ^ signB;
                  count  <= CW'(N - 1);
                  state  <= RUN;
`ifdef MULDIV_DIV_EN
                  isDiv   <= opE[1];
                  negRem  <= signA;
                  divZero <= (srcBE == {N{1'b0}});
                  remReg  <= '0;
`endif
               end
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
               if (isDiv) begin
                  remReg <= ge ? diff : shifted[N-1:0];
                  aReg   <= {aReg[N-2:0], ge};
               end else
`endif
               begin
                  acc  <= {mulSum, acc[N-1:1]};
                  bReg <= {1'b0, bReg[N-1:1]};
               end
               if (count == '0) begin
                  state <= FIX;
               end else begin
                  count <= count - CW'(1);
               end
            end
            FIX: begin
`ifdef MULDIV_DIV_EN
               if (isDiv) begin
                  hiE <= rOut;
                  loE <= qOut;
               end else
`endif
               begin
                  hiE <= prod[2*N-1:N];
                  loE <= prod[N-1:0];
               end
               doneE <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_e.sv
// tb_muldiv_e: directed self-checking bench for muldiv_e (multiply always, divide when MULDIV_DIV_EN).
module tb_muldiv_e;
   logic        CLK = 1'b0;
   logic        CLR;
   logic        startE;
   logic [1:0]  opE;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic        busyE;
   logic        doneE;
   logic [31:0] hiE;
   logic [31:0] loE;

   int checks = 0;
   int errors = 0;
   int busyCyc;
   int doneCnt;
   int doneAt;
   logic [31:0] prevHi;
   logic [31:0] prevLo;

   muldiv_e dut (
      .CLK(CLK), .CLR(CLR), .startE(startE), .opE(opE), .srcAE(srcAE), .srcBE(srcBE),
      .busyE(busyE), .doneE(doneE), .hiE(hiE), .loE(loE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, then watch 40 cycles; cycle 1 is the one after the accepting edge.
   task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int injectAt);
      startE = 1'b1; opE = op; srcAE = a; srcBE = b;
      tick();
      startE = 1'b0;
      busyCyc = 0; doneCnt = 0; doneAt = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == injectAt) begin
            startE = 1'b1; opE = 2'b00; srcAE = 32'd2; srcBE = 32'd2;
         end else begin
            startE = 1'b0;
         end
         if (busyE) busyCyc++;
         if (doneE) begin doneCnt++; doneAt = c; end
         tick();
      end
      startE = 1'b0;
   endtask

   initial begin
      CLR = 1'b1; startE = 1'b0; opE = 2'b00; srcAE = '0; srcBE = '0;
      tick(); tick();
      CLR = 1'b0;
      check("rst_busy", 32'(busyE), 32'd0);
      check("rst_done", 32'(doneE), 32'd0);
      check("rst_hi", hiE, 32'h0);
      check("rst_lo", loE, 32'h0);

      doOp(2'b00, 32'hFFFFFFFF, 32'd2, 0);
      check("multu_hi", hiE, 32'h00000001);
      check("multu_lo", loE, 32'hFFFFFFFE);
      check("multu_busy", 32'(busyCyc), 32'd33);
      check("multu_donecnt", 32'(doneCnt), 32'd1);
      check("multu_doneat", 32'(doneAt), 32'd34);

      doOp(2'b01, 32'hFFFFFFFD, 32'd5, 0);
      check("mult_hi", hiE, 32'hFFFFFFFF);
      check("mult_lo", loE, 32'hFFFFFFF1);
      check("mult_busy", 32'(busyCyc), 32'd33);

      doOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      check("multu_max_hi", hiE, 32'hFFFFFFFE);
      check("multu_max_lo", loE, 32'h00000001);

      doOp(2'b01, 32'h80000000, 32'h80000000, 0);
      check("mult_min_hi", hiE, 32'h40000000);
      check("mult_min_lo", loE, 32'h00000000);

      prevHi = hiE; prevLo = loE;
      doOp(2'b10, 32'd100, 32'd0, 0);
`ifdef MULDIV_DIV_EN
      check("divu0_hi", hiE, 32'd100);
      check("divu0_lo", loE, 32'hFFFFFFFF);
      check("divu0_busy", 32'(busyCyc), 32'd33);
      check("divu0_doneat", 32'(doneAt), 32'd34);
`else
      check("divu0_busy", 32'(busyCyc), 32'd0);
      check("divu0_donecnt", 32'(doneCnt), 32'd0);
      check("divu0_hi", hiE, prevHi);
      check("divu0_lo", loE, prevLo);
`endif

      // Abort with CLR during busy cycle 10.
      startE = 1'b1; opE = 2'b00; srcAE = 32'd7; srcBE = 32'd6;
      tick();
      startE = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      check("clr_busy_before", 32'(busyE), 32'd1);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      check("clr_busy", 32'(busyE), 32'd0);
      check("clr_hi", hiE, 32'h0);
      check("clr_lo", loE, 32'h0);
      doneCnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (doneE || busyE) doneCnt++;
         tick();
      end
      check("clr_nodone", 32'(doneCnt), 32'd0);

      doOp(2'b00, 32'd7, 32'd6, 0);
      check("restart_lo", loE, 32'd42);
      check("restart_hi", hiE, 32'd0);

`ifdef MULDIV_DIV_EN
      doOp(2'b11, 32'hFFFFFFF9, 32'd2, 0);
      check("div_lo", loE, 32'hFFFFFFFD);
      check("div_hi", hiE, 32'hFFFFFFFF);

      doOp(2'b11, 32'd100, 32'd7, 5);
      check("ignore_lo", loE, 32'd14);
      check("ignore_hi", hiE, 32'd2);
      check("ignore_donecnt", 32'(doneCnt), 32'd1);
      check("ignore_busy", 32'(busyCyc), 32'd33);

      doOp(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
      check("div_ovf_lo", loE, 32'h80000000);
      check("div_ovf_hi", hiE, 32'h0);

      doOp(2'b10, 32'hFFFFFFFF, 32'h00000010, 0);
      check("divu_big_lo", loE, 32'h0FFFFFFF);
      check("divu_big_hi", hiE, 32'h0000000F);

      doOp(2'b11, 32'hFFFFFFF9, 32'd0, 0);
      check("div0s_lo", loE, 32'hFFFFFFFF);
      check("div0s_hi", hiE, 32'hFFFFFFF9);
`else
      prevHi = hiE; prevLo = loE;
      doOp(2'b11, 32'hFFFFFFF9, 32'd2, 0);
      check("div_off_busy", 32'(busyCyc), 32'd0);
      check("div_off_hi", hiE, prevHi);
      check("div_off_lo", loE, prevLo);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_e.md
# muldiv_e

Execute-stage iterative multiply/divide unit that consumes the execute-stage control word and operands captured by the ID/EX pipeline registers. It runs MIPS-style `mult`/`multu`/`div`/`divu` over multiple cycles and writes the 2N-bit result into architectural HI/LO registers. While running it drives a busy signal to the hazard unit, which stalls the front of the pipeline.

## Interface
- N, 32, operand width; also the iteration count.
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset; synchronous, active-high.
- startE  input  1  request from the execute stage, decoded from ALUconE.
- opE  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- srcAE  input  N  multiplicand or dividend.
- srcBE  input  N  multiplier or divisor.
- busyE  output  1  high while an operation is in flight; drives the hazard unit stall.
- doneE  output  1  one-cycle pulse when HI/LO have just been written.
- hiE  output  N  HI register: product high word, or remainder.
- loE  output  N  LO register: product low word, or quotient.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: N iterations, with count from N-1 down to 0.
  - FIX: sign correction and HI/LO write.
- IDLE with startE=1:
  - Latch the operand magnitudes.
  - For signed ops, negate negative operands; record result signs.
    - Quotient sign = signA XOR signB.
    - Remainder sign = signA.
    - Product sign = signA XOR signB.
  - Clear the accumulator and go to RUN.
- startE while state ≠ IDLE is ignored. The hazard unit guarantees it is held or re-issued.
- Multiply in RUN: shift-add, one multiplier bit per cycle, LSB first, into a 2N-bit accumulator.
- Divide in RUN: restoring division, one quotient bit per cycle, MSB first, with an N+1-bit partial remainder.
- After the iteration with count=0, go to FIX.
- FIX:
  - Apply the sign corrections; all arithmetic is modulo 2^N per word.
  - Write hiE/loE, pulse doneE, and go to IDLE.
- Divide by zero (either signedness):
  - Still takes the full latency.
  - Result: hiE = srcAE, loE = all ones.
  - No trap.
- Signed overflow, div of -2^(N-1) by -1: loE = -2^(N-1), hiE = 0. This falls out of the magnitude arithmetic.
- hiE/loE hold their value until the next FIX or CLR.

## Timing
- Start is accepted at edge 0.
- Iterations run at edges 1..N.
- FIX is the state for the cycle after edge N. HI/LO are written at edge N+1.
- busyE is combinational (state ≠ IDLE):
  - High for cycles following edges 0..N, which is N+1 cycles.
  - Low in the cycle after edge N+1.
- doneE is registered:
  - High only in the cycle following edge N+1.
  - Low otherwise.
- A new start may be accepted at edge N+1 itself? No. The state is FIX then, so the earliest next start is at edge N+2.
- Reset values (CLR=1 at an edge): state IDLE, busyE=0, doneE=0, hiE=0, loE=0, counter 0.
- CLR mid-operation:
  - Aborts immediately; busyE=0 in the next cycle.
  - HI/LO are cleared, and doneE is never pulsed.
- CLR and startE together: CLR wins, and the start is dropped.

## Configuration
- MULDIV_DIV_EN defined:
  - The full unit as above.
- MULDIV_DIV_EN not defined:
  - Divider datapath and sign logic for the remainder are omitted.
  - startE with opE[1]=1 is ignored: no busy, no doneE, HI/LO unchanged.
  - Multiply behaviour and timing are identical.

## Test plan
- multu: srcAE=0xFFFFFFFF, srcBE=2.
  - hiE=0x00000001, loE=0xFFFFFFFE.
  - busyE high 33 cycles; doneE pulse in cycle 34.
- mult: srcAE=-3 (0xFFFFFFFD), srcBE=5.
  - hiE=0xFFFFFFFF, loE=0xFFFFFFF1.
- div: srcAE=-7, srcBE=2.
  - loE=0xFFFFFFFD (-3), hiE=0xFFFFFFFF (-1).
- divu: srcAE=100, srcBE=0.
  - hiE=100, loE=0xFFFFFFFF, same latency as a normal divide.
  - With MULDIV_DIV_EN undefined: busyE stays 0, HI/LO unchanged.
- Start multu 7×6, then pulse CLR in the 10th busy cycle.
  - Next cycle busyE=0, hiE=loE=0, and no doneE.
  - A new multu 7×6 then gives loE=42.
- Start div 100/7, then assert startE with multu 2×2 in busy cycle 5.
  - The second request is ignored.
  - Result loE=14, hiE=2, with exactly one doneE pulse.
